fmul_norm_round: RTL and testbench
==================================

FMUL_NORM_ROUND -- requirements
Module: fmul_norm_round

Interface
- REQ-001: Parameters: none; all widths are fixed as listed below.
- REQ-002: clk  input  1  single clock; all state updates on rising edge.
- REQ-003: reset  input  1  asynchronous, active-high reset.
- REQ-004: in_valid  input  1  upstream product word valid.
- REQ-005: in_ready  output  1  block can accept an input this cycle.
- REQ-006: in_sign  input  1  product sign (sign_a XOR sign_b).
- REQ-007: in_exp  input  10  signed two's-complement biased exponent (exp_a+exp_b-127), range -127..381.
- REQ-008: in_prod  input  64  carry-resolved mantissa product from the 64-bit adder stage; bits [47:0] = 24x24 product with hidden ones, bits [63:48] zero.
- REQ-009: in_zero  input  1  either operand was zero.
- REQ-010: out_valid  output  1  out_result/out_flags valid.
- REQ-011: out_ready  input  1  downstream accepts the result this cycle.
- REQ-012: out_result  output  32  IEEE-754 single-precision product.
- REQ-013: out_flags  output  3  {overflow, underflow, inexact}.

Function
- REQ-014: The block SHALL be a 2-stage elastic pipeline: S1 normalize, S2 round/pack. Latency is 2 cycles from input acceptance to out_valid with no backpressure.
- REQ-015: A transfer SHALL occur on in_valid&in_ready (input side) and on out_valid&out_ready (output side).
- REQ-016: Advance conditions: adv2 = !v2 | out_ready; adv1 = !v1 | adv2; in_ready = adv1 (combinational; no dependency on in_valid).
- REQ-017: Each stage register SHALL load only when its advance condition is true. Its valid bit SHALL take the upstream valid at that point.
- REQ-018: While out_valid=1 and out_ready=0, out_result and out_flags SHALL hold stable.
- REQ-019: S1 normalization when prod[47]=1: mant=prod[46:24], guard=prod[23], sticky=|prod[22:0], exp=in_exp+1.
- REQ-020: S1 normalization when prod[47]=0: mant=prod[45:23], guard=prod[22], sticky=|prod[21:0], exp=in_exp.
- REQ-021: S2 SHALL round to nearest even. Round up when guard & (sticky | mant[0]).
- REQ-022: If a round-up overflows the mantissa (all ones + 1), mant=0 and exp+1.
- REQ-023: inexact = guard | sticky, evaluated before any overflow/underflow override.
- REQ-024: If the final exp >= 255, result = {sign, 8'hFF, 23'h0} (infinity), overflow=1, inexact=1.
- REQ-025: If the final exp <= 0, result = {sign, 31'h0} (flush-to-zero, no denormals), underflow=1, inexact=1.
- REQ-026: If in_zero=1, result = {sign, 31'h0} and flags = 0, regardless of in_prod and in_exp.
- REQ-027: Exponent arithmetic SHALL be 11-bit signed internally, so no wrap-around occurs for in_exp+2.
- REQ-028: On simultaneous input accept and output accept with both stages full, throughput SHALL remain 1 result per cycle with no bubble.

Reset
- REQ-029: On reset assertion, v1, v2 and out_valid SHALL clear immediately (asynchronously); out_result=0 and out_flags=0.
- REQ-030: Data in flight during reset SHALL be discarded. in_ready SHALL be 1 from the first cycle after reset deasserts.
- REQ-031: Datapath registers other than out_result/out_flags need not be reset.

Verification
- REQ-032: 1.0*1.0: in_prod=64'h0000_4000_0000_0000, in_exp=127 -> out_valid 2 cycles later, out_result=32'h3F800000, flags=0.
- REQ-033: 1.5*1.5: in_prod=64'h0000_9000_0000_0000, in_exp=127 -> out_result=32'h40100000, flags=0.
- REQ-034: Rounding ties, with prod[47]=0, guard=1 and sticky=0:
  - lsb=0 -> no increment, inexact=1.
  - lsb=1 -> increment.
  - mant all ones -> exp+1, mant=0.
- REQ-035: Overflow and underflow:
  - in_exp=254 with prod[47]=1 -> 32'h7F800000 (sign 0), overflow=1.
  - in_exp=0 with prod[47]=0 -> 32'h00000000, underflow=1.
- REQ-036: Backpressure: hold out_ready=0 while offering 3 back-to-back inputs.
  - in_ready SHALL drop after 2 accepts.
  - Results SHALL emerge in order, unchanged, once out_ready=1.
- REQ-037: Reset mid-operation: assert reset with both stages full -> out_valid=0 in the same cycle, no stale result after deassertion.

Source files
------------

// File: rtl/fmul_norm_round.sv
// rtl/fmul_norm_round.sv - two-stage normalize and round-to-nearest-even pack for an FP32 multiplier
module fmul_norm_round (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [63:0] in_prod,
  input  logic        in_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [2:0]  out_flags
);

  logic adv1, adv2;
  logic v1;

  // Stage 1 (normalize) registers
  logic               s1_sign;
  logic               s1_zero;
  logic signed [10:0] s1_exp;
  logic [22:0]        s1_mant;
  logic               s1_guard;
  logic               s1_sticky;

  // Stage 1 combinational normalize
  logic               n_top;
  logic signed [10:0] n_exp;
  logic [22:0]        n_mant;
  logic               n_guard;
  logic               n_sticky;

  // Stage 2 combinational round/pack
  logic               round_up;
  logic [23:0]        mant_sum;
  logic signed [10:0] exp_final;
  logic               inexact;
  logic [31:0]        r_result;
  logic [2:0]         r_flags;

  // Upper product bits are always zero from the adder stage.
  logic unused_prod_bits;
  assign unused_prod_bits = ^in_prod[63:48];

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !v1 || adv2;
  assign in_ready = adv1;

  always_comb begin
    n_top    = in_prod[47];
    n_exp    = {in_exp[9], in_exp} + {10'd0, n_top};
    n_mant   = n_top ? in_prod[46:24] : in_prod[45:23];
    n_guard  = n_top ? in_prod[23] : in_prod[22];
    n_sticky = n_top ? (|in_prod[22:0]) : (|in_prod[21:0]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1 <= 1'b0;
    end else if (adv1) begin
      v1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      s1_sign   <= in_sign;
      s1_zero   <= in_zero;
      s1_exp    <= n_exp;
      s1_mant   <= n_mant;
      s1_guard  <= n_guard;
      s1_sticky <= n_sticky;
    end
  end

  always_comb begin
    round_up  = s1_guard && (s1_sticky || s1_mant[0]);
    mant_sum  = {1'b0, s1_mant} + {23'd0, round_up};
    // A carry out of the 23-bit field leaves the mantissa zero and bumps the exponent.
    exp_final = s1_exp + {10'd0, mant_sum[23]};
    inexact   = s1_guard || s1_sticky;
    r_result  = {s1_sign, exp_final[7:0], mant_sum[22:0]};
    r_flags   = {2'b00, inexact};
    if (s1_zero) begin
      r_result = {s1_sign, 31'h0};
      r_flags  = 3'b000;
    end else if (exp_final >= 11'sd255) begin
      r_result = {s1_sign, 8'hFF, 23'h0};
      r_flags  = 3'b101;
    end else if (exp_final <= 11'sd0) begin
      r_result = {s1_sign, 31'h0};
      r_flags  = 3'b011;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= 32'h0;
      out_flags  <= 3'b000;
    end else if (adv2) begin
      out_valid <= v1;
      if (v1) begin
        out_result <= r_result;
        out_flags  <= r_flags;
      end
    end
  end

endmodule

// File: tb/tb_fmul_norm_round.sv
// tb/tb_fmul_norm_round.sv - directed self-checking bench for fmul_norm_round
module tb_fmul_norm_round;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [63:0] in_prod;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;

  int checks = 0;
  int errors = 0;

  fmul_norm_round dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_prod    (in_prod),
    .in_zero    (in_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic s, input logic [9:0] e, input logic [63:0] p, input logic z);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_prod  = p;
    in_zero  = z;
  endtask

  // Sends one operand with out_ready=1 and checks the packed result; called at a negedge.
  task automatic run_one(input string tag, input logic s, input logic [9:0] e,
                         input logic [63:0] p, input logic z,
                         input logic [31:0] exp_res, input logic [2:0] exp_flags);
    bit seen;
    seen = 0;
    out_ready = 1'b1;
    drive(s, e, p, z);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (out_valid) seen = 1;
      else @(negedge clk);
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_result"}, out_result, exp_res);
    check({tag, "_flags"}, {29'd0, out_flags}, {29'd0, exp_flags});
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 10'd0;
    in_prod   = 64'd0;
    in_zero   = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_result", out_result, 32'h0);
    check("rst_out_flags", {29'd0, out_flags}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Latency: 1.0*1.0 accepted at one edge, out_valid after the second following edge
    drive(1'b0, 10'd127, 64'h0000_4000_0000_0000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("lat_cycle1_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_cycle2_valid", {31'd0, out_valid}, 32'd1);
    check("one_result", out_result, 32'h3F80_0000);
    check("one_flags", {29'd0, out_flags}, 32'd0);
    @(negedge clk);

    run_one("mul_1p5", 1'b0, 10'd127, 64'h0000_9000_0000_0000, 1'b0, 32'h4010_0000, 3'b000);
    run_one("tie_lsb0", 1'b0, 10'd127, 64'h0000_4000_0040_0000, 1'b0, 32'h3F80_0000, 3'b001);
    run_one("tie_lsb1", 1'b0, 10'd127, 64'h0000_4000_00C0_0000, 1'b0, 32'h3F80_0002, 3'b001);
    run_one("tie_carry", 1'b0, 10'd127, 64'h0000_7FFF_FFC0_0000, 1'b0, 32'h4000_0000, 3'b001);
    run_one("sticky_up", 1'b0, 10'd127, 64'h0000_4000_0040_0001, 1'b0, 32'h3F80_0001, 3'b001);
    run_one("neg_one", 1'b1, 10'd127, 64'h0000_4000_0000_0000, 1'b0, 32'hBF80_0000, 3'b000);
    run_one("max_norm", 1'b0, 10'd254, 64'h0000_4000_0000_0000, 1'b0, 32'h7F00_0000, 3'b000);
    run_one("overflow", 1'b0, 10'd254, 64'h0000_8000_0000_0000, 1'b0, 32'h7F80_0000, 3'b101);
    run_one("underflow", 1'b0, 10'd0, 64'h0000_4000_0000_0000, 1'b0, 32'h0000_0000, 3'b011);
    run_one("exp_max_carry", 1'b1, 10'd381, 64'h0000_FFFF_FF80_0000, 1'b0, 32'hFF80_0000, 3'b101);
    run_one("exp_min", 1'b0, 10'h381, 64'h0000_4000_0000_0000, 1'b0, 32'h0000_0000, 3'b011);
    run_one("zero_in", 1'b1, 10'd254, 64'h0000_FFFF_FFFF_FFFF, 1'b1, 32'h8000_0000, 3'b000);

    // Backpressure: three back-to-back inputs with out_ready low
    out_ready = 1'b0;
    drive(1'b0, 10'd127, 64'h0000_4000_0000_0000, 1'b0);
    check("bp_ready_a", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 10'd127, 64'h0000_9000_0000_0000, 1'b0);
    check("bp_ready_b", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 10'd128, 64'h0000_4000_0000_0000, 1'b0);
    check("bp_ready_c_drop", {31'd0, in_ready}, 32'd0);
    check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_result", out_result, 32'h3F80_0000);
      check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_ready_release", {31'd0, in_ready}, 32'd1);
    check("bp_out_a", out_result, 32'h3F80_0000);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_out_b_valid", {31'd0, out_valid}, 32'd1);
    check("bp_out_b", out_result, 32'h4010_0000);
    @(negedge clk);
    check("bp_out_c_valid", {31'd0, out_valid}, 32'd1);
    check("bp_out_c", out_result, 32'h4000_0000);
    @(negedge clk);
    check("bp_drained", {31'd0, out_valid}, 32'd0);

    // Reset with both stages full
    out_ready = 1'b0;
    drive(1'b0, 10'd127, 64'h0000_9000_0000_0000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 10'd128, 64'h0000_4000_0000_0000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_full_ready", {31'd0, in_ready}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_result", out_result, 32'h0);
    check("mid_rst_flags", {29'd0, out_flags}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    check("mid_post_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_no_stale", {31'd0, out_valid}, 32'd0);
    end

    run_one("post_rst", 1'b0, 10'd127, 64'h0000_4000_0000_0000, 1'b0, 32'h3F80_0000, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
